// File: rtl/fpg8_pkg.sv
// Shared constants and timer state encoding for the fpg8 control path.
package fpg8_pkg;

    localparam int unsigned BUS_WIDTH        = 16;
    localparam int unsigned DEFAULT_PRESCALE = 1;
    localparam int unsigned STATE_W          = 2;

    typedef enum logic [STATE_W-1:0] {
        TIMER_IDLE    = 2'b00,
        TIMER_RUN     = 2'b01,
        TIMER_EXPIRED = 2'b10
    } timer_state_e;

endpackage

// File: rtl/quantum_timer_if.sv
// Control-unit <-> quantum timer signal bundle.
interface quantum_timer_if #(
    parameter int unsigned WIDTH = fpg8_pkg::BUS_WIDTH
);
    import fpg8_pkg::*;

    logic [WIDTH-1:0]   bus_in;
    logic               timer_in;
    logic               privileged;
    logic               con_ROM_out;
    logic               timeout;
    logic [WIDTH-1:0]   count;
    logic [STATE_W-1:0] REG_OUT_TIMER;

    modport master (
        output bus_in, timer_in, privileged, con_ROM_out,
        input  timeout, count, REG_OUT_TIMER
    );

    modport slave (
        input  bus_in, timer_in, privileged, con_ROM_out,
        output timeout, count, REG_OUT_TIMER
    );

endinterface

// File: rtl/quantum_timer_tick_divider.sv
// Prescaler: emits a one-cycle tick every PRESCALE enabled cycles.
module tick_divider
    import fpg8_pkg::*;
#(
    parameter int unsigned PRESCALE = DEFAULT_PRESCALE
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned   CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // With PRESCALE=1 LAST is 0, the counter never leaves 0 and tick follows enable.
    assign tick = enable && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/quantum_timer.sv
// Preemption quantum timer: loads from the bus, counts down while unprivileged,
// raises timeout on expiry until acknowledged.
module quantum_timer
    import fpg8_pkg::*;
#(
    parameter int unsigned PRESCALE = DEFAULT_PRESCALE,
    parameter int unsigned WIDTH    = BUS_WIDTH
) (
    input  logic           clk,
    input  logic           reset,
    quantum_timer_if.slave tif
);

    timer_state_e     state_q;
    timer_state_e     state_d;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             timeout_q;
    logic             timeout_d;
    logic             tick;
    logic             tick_en;

    assign tick_en = (state_q == TIMER_RUN) && !tif.privileged;

    tick_divider #(
        .PRESCALE(PRESCALE)
    ) u_tick_divider (
        .clk   (clk),
        .reset (reset),
        .clear (tif.timer_in),
        .enable(tick_en),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (tif.timer_in) begin
            // Load beats everything, including a simultaneous acknowledge.
            count_d = tif.bus_in;
            state_d = (tif.bus_in != '0) ? TIMER_RUN : TIMER_IDLE;
        end else begin
            case (state_q)
                TIMER_IDLE: ;
                TIMER_RUN: begin
                    if (tick) begin
                        count_d = count_q - WIDTH'(1);
                        if (count_q == WIDTH'(1)) begin
                            state_d = TIMER_EXPIRED;
                        end
                    end
                end
                TIMER_EXPIRED: begin
                    if (tif.con_ROM_out) begin
                        state_d = TIMER_IDLE;
                    end
                end
                default: state_d = TIMER_IDLE;
            endcase
        end
        timeout_d = (state_d == TIMER_EXPIRED);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= TIMER_IDLE;
            count_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            timeout_q <= timeout_d;
        end
    end

    assign tif.timeout       = timeout_q;
    assign tif.count         = count_q;
    assign tif.REG_OUT_TIMER = state_q;

endmodule

// File: tb/tb_quantum_timer.sv
// Directed bench for quantum_timer at PRESCALE=1 and PRESCALE=4.
module tb_quantum_timer;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    quantum_timer_if #(.WIDTH(16)) if1 ();
    quantum_timer_if #(.WIDTH(16)) if4 ();

    quantum_timer #(.PRESCALE(1), .WIDTH(16)) dut1 (
        .clk  (clk),
        .reset(reset),
        .tif  (if1.slave)
    );

    quantum_timer #(.PRESCALE(4), .WIDTH(16)) dut4 (
        .clk  (clk),
        .reset(reset),
        .tif  (if4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        if1.bus_in = '0; if1.timer_in = 1'b0; if1.privileged = 1'b0; if1.con_ROM_out = 1'b0;
        if4.bus_in = '0; if4.timer_in = 1'b0; if4.privileged = 1'b0; if4.con_ROM_out = 1'b0;
        #3;
        checks++;
        if (if1.count !== 16'd0 || if1.timeout !== 1'b0 || if1.REG_OUT_TIMER !== 2'b00) begin
            failures++;
            $display("FAIL reset_p1 count=%0d timeout=%b state=%b exp 0/0/00",
                     if1.count, if1.timeout, if1.REG_OUT_TIMER);
        end
        checks++;
        if (if4.count !== 16'd0 || if4.timeout !== 1'b0 || if4.REG_OUT_TIMER !== 2'b00) begin
            failures++;
            $display("FAIL reset_p4 count=%0d timeout=%b state=%b exp 0/0/00",
                     if4.count, if4.timeout, if4.REG_OUT_TIMER);
        end
        step(2);
        reset = 1'b0;
        step(1);
        checks++;
        if (if1.REG_OUT_TIMER !== 2'b00 || if1.count !== 16'd0) begin
            failures++;
            $display("FAIL reset_release state=%b count=%0d exp 00/0", if1.REG_OUT_TIMER, if1.count);
        end
    endtask

    task automatic test_countdown();
        if1.bus_in = 16'd5; if1.timer_in = 1'b1;
        step(1);
        if1.timer_in = 1'b0; if1.bus_in = '0;
        checks++;
        if (if1.count !== 16'd5 || if1.REG_OUT_TIMER !== 2'b01 || if1.timeout !== 1'b0) begin
            failures++;
            $display("FAIL cd_load count=%0d state=%b timeout=%b exp 5/01/0",
                     if1.count, if1.REG_OUT_TIMER, if1.timeout);
        end
        for (int k = 1; k <= 5; k++) begin
            step(1);
            checks++;
            if (if1.count !== 16'(5 - k) || if1.timeout !== (k == 5)) begin
                failures++;
                $display("FAIL cd_edge%0d count=%0d timeout=%b exp %0d/%b",
                         k, if1.count, if1.timeout, 5 - k, (k == 5));
            end
        end
        step(3);
        checks++;
        if (if1.count !== 16'd0 || if1.timeout !== 1'b1 || if1.REG_OUT_TIMER !== 2'b10) begin
            failures++;
            $display("FAIL cd_hold count=%0d timeout=%b state=%b exp 0/1/10",
                     if1.count, if1.timeout, if1.REG_OUT_TIMER);
        end
        if1.con_ROM_out = 1'b1;
        step(1);
        if1.con_ROM_out = 1'b0;
        checks++;
        if (if1.timeout !== 1'b0 || if1.REG_OUT_TIMER !== 2'b00) begin
            failures++;
            $display("FAIL cd_ack timeout=%b state=%b exp 0/00", if1.timeout, if1.REG_OUT_TIMER);
        end
    endtask

    task automatic test_prescale();
        int exp_cnt;
        if4.bus_in = 16'd3; if4.timer_in = 1'b1;
        step(1);
        if4.timer_in = 1'b0; if4.bus_in = '0;
        for (int k = 1; k <= 12; k++) begin
            step(1);
            exp_cnt = 3 - k / 4;
            checks++;
            if (if4.count !== 16'(exp_cnt) || if4.timeout !== (k == 12)) begin
                failures++;
                $display("FAIL ps_edge%0d count=%0d timeout=%b exp %0d/%b",
                         k, if4.count, if4.timeout, exp_cnt, (k == 12));
            end
        end
        checks++;
        if (if4.REG_OUT_TIMER !== 2'b10) begin
            failures++;
            $display("FAIL ps_expired state=%b exp 10", if4.REG_OUT_TIMER);
        end
        if4.con_ROM_out = 1'b1;
        step(1);
        if4.con_ROM_out = 1'b0;
        checks++;
        if (if4.timeout !== 1'b0 || if4.REG_OUT_TIMER !== 2'b00) begin
            failures++;
            $display("FAIL ps_ack timeout=%b state=%b exp 0/00", if4.timeout, if4.REG_OUT_TIMER);
        end
    endtask

    task automatic test_privileged();
        if1.bus_in = 16'd4; if1.timer_in = 1'b1;
        step(1);
        if1.timer_in = 1'b0; if1.bus_in = '0;
        step(2);
        checks++;
        if (if1.count !== 16'd2) begin
            failures++;
            $display("FAIL priv_pre count=%0d exp 2", if1.count);
        end
        if1.privileged = 1'b1;
        for (int k = 3; k <= 12; k++) begin
            step(1);
            checks++;
            if (if1.count !== 16'd2 || if1.timeout !== 1'b0) begin
                failures++;
                $display("FAIL priv_hold_L%0d count=%0d timeout=%b exp 2/0", k, if1.count, if1.timeout);
            end
        end
        if1.privileged = 1'b0;
        step(1);
        checks++;
        if (if1.count !== 16'd1 || if1.timeout !== 1'b0) begin
            failures++;
            $display("FAIL priv_L13 count=%0d timeout=%b exp 1/0", if1.count, if1.timeout);
        end
        step(1);
        checks++;
        if (if1.count !== 16'd0 || if1.timeout !== 1'b1) begin
            failures++;
            $display("FAIL priv_L14 count=%0d timeout=%b exp 0/1", if1.count, if1.timeout);
        end
        if1.privileged = 1'b1;
        if1.con_ROM_out = 1'b1;
        step(1);
        if1.con_ROM_out = 1'b0;
        if1.privileged = 1'b0;
        checks++;
        if (if1.timeout !== 1'b0 || if1.REG_OUT_TIMER !== 2'b00) begin
            failures++;
            $display("FAIL priv_ack timeout=%b state=%b exp 0/00", if1.timeout, if1.REG_OUT_TIMER);
        end
    endtask

    task automatic test_disarm();
        if1.bus_in = 16'd10; if1.timer_in = 1'b1;
        step(1);
        if1.timer_in = 1'b0;
        if1.con_ROM_out = 1'b1;
        step(3);
        if1.con_ROM_out = 1'b0;
        checks++;
        if (if1.count !== 16'd7 || if1.REG_OUT_TIMER !== 2'b01) begin
            failures++;
            $display("FAIL dis_run count=%0d state=%b exp 7/01", if1.count, if1.REG_OUT_TIMER);
        end
        if1.bus_in = 16'd0; if1.timer_in = 1'b1;
        step(1);
        if1.timer_in = 1'b0;
        checks++;
        if (if1.count !== 16'd0 || if1.REG_OUT_TIMER !== 2'b00 || if1.timeout !== 1'b0) begin
            failures++;
            $display("FAIL dis_load0 count=%0d state=%b timeout=%b exp 0/00/0",
                     if1.count, if1.REG_OUT_TIMER, if1.timeout);
        end
        step(5);
        checks++;
        if (if1.timeout !== 1'b0 || if1.REG_OUT_TIMER !== 2'b00) begin
            failures++;
            $display("FAIL dis_idle timeout=%b state=%b exp 0/00", if1.timeout, if1.REG_OUT_TIMER);
        end
        if1.bus_in = 16'd2; if1.timer_in = 1'b1;
        step(1);
        if1.timer_in = 1'b0; if1.bus_in = '0;
        step(1);
        checks++;
        if (if1.count !== 16'd1 || if1.timeout !== 1'b0) begin
            failures++;
            $display("FAIL dis_rearm1 count=%0d timeout=%b exp 1/0", if1.count, if1.timeout);
        end
        step(1);
        checks++;
        if (if1.count !== 16'd0 || if1.timeout !== 1'b1) begin
            failures++;
            $display("FAIL dis_rearm2 count=%0d timeout=%b exp 0/1", if1.count, if1.timeout);
        end
        if1.con_ROM_out = 1'b1;
        step(1);
        if1.con_ROM_out = 1'b0;
    endtask

    task automatic test_load_vs_ack();
        if1.bus_in = 16'd1; if1.timer_in = 1'b1;
        step(1);
        if1.timer_in = 1'b0;
        step(1);
        checks++;
        if (if1.REG_OUT_TIMER !== 2'b10 || if1.timeout !== 1'b1) begin
            failures++;
            $display("FAIL lva_expired state=%b timeout=%b exp 10/1", if1.REG_OUT_TIMER, if1.timeout);
        end
        if1.bus_in = 16'd9; if1.timer_in = 1'b1; if1.con_ROM_out = 1'b1;
        step(1);
        if1.timer_in = 1'b0; if1.con_ROM_out = 1'b0; if1.bus_in = '0;
        checks++;
        if (if1.REG_OUT_TIMER !== 2'b01 || if1.count !== 16'd9 || if1.timeout !== 1'b0) begin
            failures++;
            $display("FAIL lva_both state=%b count=%0d timeout=%b exp 01/9/0",
                     if1.REG_OUT_TIMER, if1.count, if1.timeout);
        end
        step(1);
        checks++;
        if (if1.count !== 16'd8) begin
            failures++;
            $display("FAIL lva_next count=%0d exp 8", if1.count);
        end
        if1.timer_in = 1'b1;
        step(1);
        if1.timer_in = 1'b0;
    endtask

    task automatic test_async_reset();
        if4.bus_in = 16'd1; if4.timer_in = 1'b1;
        step(1);
        if4.timer_in = 1'b0; if4.bus_in = '0;
        step(4);
        checks++;
        if (if4.timeout !== 1'b1) begin
            failures++;
            $display("FAIL ar_p4_expired timeout=%b exp 1", if4.timeout);
        end
        if1.bus_in = 16'd300; if1.timer_in = 1'b1;
        step(1);
        if1.timer_in = 1'b0; if1.bus_in = '0;
        checks++;
        if (if1.count !== 16'd300 || if1.REG_OUT_TIMER !== 2'b01) begin
            failures++;
            $display("FAIL ar_loaded count=%0d state=%b exp 300/01", if1.count, if1.REG_OUT_TIMER);
        end
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (if1.count !== 16'd0 || if1.timeout !== 1'b0 || if1.REG_OUT_TIMER !== 2'b00) begin
            failures++;
            $display("FAIL ar_p1 count=%0d timeout=%b state=%b exp 0/0/00",
                     if1.count, if1.timeout, if1.REG_OUT_TIMER);
        end
        checks++;
        if (if4.timeout !== 1'b0 || if4.REG_OUT_TIMER !== 2'b00) begin
            failures++;
            $display("FAIL ar_p4 timeout=%b state=%b exp 0/00", if4.timeout, if4.REG_OUT_TIMER);
        end
        #2;
        reset = 1'b0;
        step(1);
        if1.con_ROM_out = 1'b1; if4.con_ROM_out = 1'b1;
        step(2);
        if1.con_ROM_out = 1'b0; if4.con_ROM_out = 1'b0;
        step(1);
        checks++;
        if (if1.REG_OUT_TIMER !== 2'b00 || if1.count !== 16'd0 || if1.timeout !== 1'b0) begin
            failures++;
            $display("FAIL ar_idle_ack state=%b count=%0d timeout=%b exp 00/0/0",
                     if1.REG_OUT_TIMER, if1.count, if1.timeout);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_countdown();
        test_prescale();
        test_privileged();
        test_disarm();
        test_load_vs_ack();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/quantum_timer.md
# quantum_timer

Preemption timer consumed by the control unit's `timeout` input. It is loaded from the 16-bit system bus when the control unit asserts `timer_in` (E14_2). It counts down only while the processor is unprivileged. On expiry it raises `timeout` and holds it until the control unit acknowledges with `con_ROM_out` (T1), which starts the preemption vector sequence.

## Interface
- `PRESCALE`, default 1: unprivileged clock cycles per count decrement; legal range ≥1.
- `WIDTH`, default 16: counter and bus width.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  reset; asynchronous, active-high.
- `bus_in`  in  WIDTH  system bus; the quantum value, sampled when `timer_in`=1.
- `timer_in`  in  1  load strobe from the control unit.
- `privileged`  in  1  PSW bit 2; 1 freezes counting.
- `con_ROM_out`  in  1  expiry acknowledge (T1 state).
- `timeout`  out  1  registered; 1 only in state EXPIRED.
- `count`  out  WIDTH  current remaining quantum, for debug and LED display.
- `REG_OUT_TIMER`  out  2  current state encoding, for debug.

## Operation
- States: IDLE=2'b00 (disarmed), RUN=2'b01, EXPIRED=2'b10. Encoding 2'b11 is illegal and goes to IDLE on the next edge.
- Reset (async): state=IDLE, `count`=0, prescaler=0, `timeout`=0.
- `timer_in`=1 has top priority in any state:
  - `count`←`bus_in`, prescaler←0.
  - Next state is RUN if `bus_in`≠0, else IDLE. Loading 0 disarms the timer.
- RUN with `privileged`=0:
  - Prescaler increments each cycle.
  - At prescaler=PRESCALE-1: prescaler←0, `count`←`count`-1 (the "tick").
  - If the tick occurs with `count`=1: `count`←0, state←EXPIRED.
- RUN with `privileged`=1: prescaler and `count` hold. No partial-prescale loss; counting resumes where it stopped.
- EXPIRED:
  - `count` holds 0 and `timeout`=1.
  - `con_ROM_out`=1 → IDLE, `timeout`←0.
  - `privileged` has no effect in this state.
- IDLE: everything holds; `con_ROM_out` is ignored.
- `con_ROM_out` in RUN is ignored.
- Simultaneous `timer_in` and `con_ROM_out`: the load wins, and the acknowledge is discarded.
- Arithmetic: unsigned WIDTH-bit values. Underflow is impossible, because RUN is never entered with `count`=0.

## Timing
- Load latency: `count` and state update on the edge that samples `timer_in`. Call this edge L.
- With PRESCALE=P and `privileged` continuously 0 after loading N:
  - Decrements occur at edges L+P, L+2P, …, L+N·P.
  - `timeout` is visible from L+N·P to the acknowledge edge.
- Privileged cycles add 1:1 delay; they do not consume prescale.
- `timeout` falls on the edge that samples `con_ROM_out`=1. It is never combinationally derived from inputs.
- Reset asserted mid-count: outputs go to their reset values immediately, with no clock needed. Deassertion is synchronous to `clk` by the system reset generator.

## Structure
- Shared package `fpg8_pkg`:
  - Timer state localparams (TIMER_IDLE/RUN/EXPIRED).
  - Bus width constant (16).
  - Default PRESCALE.
- One sub-module `tick_divider`:
  - Inputs: `clk`, `reset`, `clear`, `enable`.
  - Output: `tick`, a one-cycle pulse when an enabled count reaches PRESCALE-1.
  - Counter width is `$clog2(PRESCALE)`, minimum 1.
  - For PRESCALE=1, `tick`=`enable`.
- The top level holds the state machine and the `count` register.

## Test plan
- Load 5, PRESCALE=1, `privileged`=0: `count` goes 5,4,3,2,1,0 on consecutive edges. `timeout` rises at L+5 and stays high until `con_ROM_out`. After the ack edge: `timeout`=0, state IDLE.
- PRESCALE=4, load 3, `privileged`=0: decrements at L+4, L+8, L+12; `timeout` at L+12.
- Load 4, PRESCALE=1, `privileged`=1 for 10 cycles starting at L+2: `count` holds 2 throughout; `timeout` at L+14.
- In RUN with `count`=7, load `bus_in`=0: state becomes IDLE, `count`=0, `timeout` never rises. Then load 2: expiry after 2 unprivileged edges.
- In EXPIRED, `timer_in`=1 (`bus_in`=9) together with `con_ROM_out`=1: state RUN, `count`=9, `timeout`=0.
- Assert `reset` asynchronously between edges in RUN with `count`=300: `count`=0, `timeout`=0, state IDLE before the next edge. `con_ROM_out` pulses while in IDLE are ignored.
